// File: rtl/seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_multiplier: signed sign-magnitude shift-add multiplier with a    |
// | full-width product and a rescaled, saturated WIDTH-bit result.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Prod,
  output logic [WIDTH-1:0]     Res,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 ovf_q, ovf_d;

  // Upper half is WIDTH+1 bits wide so adding a magnitude of 2^(WIDTH-1) never carries out.
  logic [WIDTH:0]              w_sum;
  logic [2*WIDTH-1:0]          w_prod;
  logic signed [2*WIDTH-1:0]   w_shift;
  logic [WIDTH:0]              w_hi;
  logic                        w_fits;
  logic [WIDTH-1:0]            w_res;

  assign w_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, mag_a_q};
  assign w_prod  = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign w_shift = $signed(w_prod) >>> FRAC;
  assign w_hi    = w_shift[2*WIDTH-1:WIDTH-1];
  assign w_fits  = (&w_hi) | ~(|w_hi);
  assign w_res   = w_fits ? w_shift[WIDTH-1:0] :
                   (w_shift[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
          mag_a_d = A[WIDTH-1] ? -A : A;
          mag_b_d = B[WIDTH-1] ? -B : B;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = mag_b_q[0] ? ({w_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        prod_d  = w_prod;
        res_d   = w_res;
        ovf_d   = ~w_fits;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Prod = prod_q;
  assign Res  = res_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire
